seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for the 8-digit multiplexed 7-segment display. It time-multiplexes eight 4-bit hex digits onto one shared segment bus and drives the 3-bit digit index that feeds the downstream 3-to-8 active-low digit-select decoder. Digit index and segment pattern are always registered on the same edge, so the decoder output and the segment bus change together. A frame snapshot prevents tearing when the displayed value changes mid-scan.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `SCAN_HZ`, default 1000: per-digit dwell rate. `DIV = CLK_HZ/SCAN_HZ` is clamped to a minimum of 2.
- `clk`  in  1: single system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: scan enable. Level-sensitive.
- `data`  in  32: eight hex digits; digit i = `data[4i+3:4i]`.
- `dp`  in  8: decimal point per digit, active-high.
- `blank`  in  8: per-digit blank mask, active-high.
- `sel`  out  3: current digit index, driving the decoder's select input.
- `seg`  out  8: segments `{dp,g,f,e,d,c,b,a}`, active-low.
- `frame_tick`  out  1: one-cycle pulse at the start of each frame.

## Operation
- **Reset values:** state IDLE, prescaler 0, `sel` = 3'd0, `seg` = 8'hFF, `frame_tick` = 0, snapshot = 0.
- **States:** IDLE and SCAN.
  - IDLE: `sel` held 0, `seg` = 8'hFF.
  - IDLE → SCAN on an edge with `en` = 1. On that edge:
    - prescaler is cleared;
    - `data`, `dp` and `blank` are captured into the snapshot;
    - `sel` = 0 and `seg` = encode(digit 0 of the new snapshot);
    - `frame_tick` pulses.
  - SCAN → IDLE on the first edge with `en` = 0: `seg` = 8'hFF and `sel` = 0 on that same edge; the prescaler is cleared.
- **Prescaler:** counts 0 to DIV-1 in SCAN. A terminal count produces a dwell tick and the prescaler returns to 0.
- **Dwell tick:**
  - `sel` advances mod 8.
  - On wrap 7 → 0: a new snapshot is captured and `frame_tick` = 1 for one cycle.
  - `seg` is updated on the same edge as `sel`, using the digit of the snapshot valid after that edge.
- **Encoding:** full hex 0–F with the standard common-anode patterns: 0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80, A = 8'h88, F = 8'h8E.
  - `seg[7]` = ~`dp[i]`.
  - `blank[i]` = 1 forces 8'hFF, decimal point included.
- Inputs changing mid-frame have no visible effect until the next frame start.

## Timing
- Latency from `en` rise to the first valid `sel`/`seg`: 1 edge.
- Each digit is held exactly DIV cycles; a frame is 8·DIV cycles.
- `frame_tick` is coincident with `sel` becoming 0.
- Snapshot latency: new `data` appears at most 8·DIV + 1 cycles after it is applied.
- **Asynchronous reset mid-frame:** all outputs return immediately to their reset values. After release, the block stays in IDLE until an edge with `en` = 1.
- **`en` toggled 1 → 0 → 1 on consecutive edges:** a full restart (new snapshot, `sel` = 0); no partial frame resumes.

## Configuration
- **`SEG_LZ_BLANK_EN` defined:** leading-zero suppression. Digits above the most significant nonzero digit of the snapshot are blanked, unless their `dp` bit is set. Digit 0 is never suppressed. The suppression mask is computed once per snapshot capture and registered with it.
- **Not defined:** only the `blank` input controls blanking. No suppression logic is present.

## Structure
- **Shared package:** the hex-to-segment constants (16 patterns), `SEG_OFF` = 8'hFF, digit count 8, the index width 3, and the state encodings IDLE = 1'b0, SCAN = 1'b1.
- **One sub-module, `hex2seg`:** purely combinational 4-bit to 7-bit active-low encoder, instantiated once on the next-digit path.
- Everything else (prescaler, FSM, snapshot, mask) lives in the top module.

## Test plan
All scenarios use CLK_HZ = 8, SCAN_HZ = 2, giving DIV = 4.
1. Reset with `en` = 1 held, then release: first edge gives `sel` = 0, `frame_tick` = 1; `sel` advances every 4 cycles 0…7→0, with `frame_tick` again at cycle 32.
2. `data` = 32'h7654_3210, `dp` = 0, `blank` = 0: `seg` per digit is C0, F9, A4, B0, 99, 92, 82, F8, each aligned with `sel`.
3. `data` changed to 32'hFFFF_FFFF while `sel` = 3: digits 3–7 still show the old values; from the next `frame_tick`, all digits show 8'h8E.
4. `blank` = 8'h0F, `dp` = 8'h10: digits 0–3 show FF; digit 4 shows the pattern with bit 7 = 0.
5. `en` dropped while `sel` = 5: `seg` = FF and `sel` = 0 next edge. Re-raising `en` restarts at digit 0 with a fresh snapshot. An asynchronous `rst_n` pulse mid-dwell gives immediate reset values.
6. With `SEG_LZ_BLANK_EN` and `data` = 32'h0000_0120: digits 3–7 show FF, digit 2 = F9, digit 1 = A4, digit 0 = C0. Without the macro, digits 3–7 show C0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  // All segments dark, decimal point included (active-low bus).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Common-anode hex patterns {dp,g,f,e,d,c,b,a}, dp bit held off (1).
  // Indexed by the hex value: HEX_SEG[4'hA] is the pattern for 'A'.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,  // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,  // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,  // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0   // 3 2 1 0
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/seg_scan_ctrl_hex2seg.sv
// Hex nibble to 7-segment active-low pattern {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module hex2seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Table lookup; the decimal point is handled by the caller.
  always_comb begin
    seg_n = HEX_SEG[hex][6:0];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller: time-multiplexes 8 hex digits onto one segment bus with a per-frame snapshot.
// Latency: 1 edge from en rise to first digit; each digit dwells DIV cycles; frame is 8*DIV.
// Backpressure: none; en is a level gate. Optional leading-zero blanking under `SEG_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      data,
  input  logic [7:0]       dp,
  input  logic [7:0]       blank,
  output logic [IDX_W-1:0] sel,
  output logic [7:0]       seg,
  output logic             frame_tick
);

  localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int PW      = $clog2(DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick_q, tick_d;
  logic [31:0]      snap_data_q, snap_data_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic [7:0]       snap_blank_q, snap_blank_d;

  logic             capture;   // load a fresh snapshot on this edge (frame start)
  logic             load_seg;  // refresh the segment bus from the next digit
  logic             seg_off;   // force the bus dark (idle / leaving scan)
  logic [3:0]       nib;
  logic [6:0]       nib_seg;
  logic             digit_off;

`ifdef SEG_LZ_BLANK_EN
  logic [7:0] lz_mask_q, lz_mask_d;

  // Digits above the top nonzero digit are suppressed unless their dp is lit; digit 0 never.
  function automatic logic [7:0] calc_lz_mask(input logic [31:0] d, input logic [7:0] p);
    logic all_zero_above;
    calc_lz_mask   = '0;
    all_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero_above  = all_zero_above & (d[4*i +: 4] == 4'h0);
      calc_lz_mask[i] = all_zero_above & ~p[i];
    end
  endfunction
`endif

  // FSM next-state, prescaler and digit index; decides when to capture and refresh segments.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sel_d    = sel_q;
    capture  = 1'b0;
    load_seg = 1'b0;
    seg_off  = 1'b0;
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        sel_d   = '0;
        seg_off = 1'b1;
        if (en) begin
          state_d  = SCAN;
          capture  = 1'b1;
          load_seg = 1'b1;
          seg_off  = 1'b0;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          presc_d = '0;
          sel_d   = '0;
          seg_off = 1'b1;
        end else if (presc_q == PRESC_MAX) begin
          presc_d  = '0;
          sel_d    = sel_q + IDX_W'(1);
          load_seg = 1'b1;
          capture  = (sel_q == LAST_IDX);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    tick_d = capture;
  end

  // Snapshot valid after this edge; the next digit is taken from it so seg tracks sel.
  always_comb begin
    snap_data_d  = capture ? data  : snap_data_q;
    snap_dp_d    = capture ? dp    : snap_dp_q;
    snap_blank_d = capture ? blank : snap_blank_q;
`ifdef SEG_LZ_BLANK_EN
    lz_mask_d    = capture ? calc_lz_mask(data, dp) : lz_mask_q;
    digit_off    = snap_blank_d[sel_d] | lz_mask_d[sel_d];
`else
    digit_off    = snap_blank_d[sel_d];
`endif
    nib          = snap_data_d[{sel_d, 2'b00} +: 4];
  end

  hex2seg u_hex2seg (
    .hex   (nib),
    .seg_n (nib_seg)
  );

  // Segment bus next value: dark, refreshed with the next digit, or held.
  always_comb begin
    seg_d = seg_q;
    if (seg_off) begin
      seg_d = SEG_OFF;
    end else if (load_seg) begin
      seg_d = digit_off ? SEG_OFF : {~snap_dp_d[sel_d], nib_seg};
    end
  end

  // State, prescaler, outputs and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      sel_q        <= '0;
      seg_q        <= SEG_OFF;
      tick_q       <= 1'b0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
`ifdef SEG_LZ_BLANK_EN
      lz_mask_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      tick_q       <= tick_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
`ifdef SEG_LZ_BLANK_EN
      lz_mask_q    <= lz_mask_d;
`endif
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIV = 4: cycle model feeding a scoreboard plus directed pattern checks.
// Latency: model predicts outputs per edge; compared on the following falling edge.
// Backpressure: none; honours `SEG_LZ_BLANK_EN for the leading-zero expectation.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;
  localparam int BOUND = 100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [31:0] data  = '0;
  logic [7:0]  dp    = '0;
  logic [7:0]  blank = '0;
  logic [2:0]  sel;
  logic [7:0]  seg;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  obs_seg [8];
  logic [7:0]  exp2    [8];

  // Reference model state: one frame-position counter instead of prescaler + index.
  logic        m_run   = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_data  = '0;
  logic [7:0]  m_dp    = '0;
  logic [7:0]  m_blank = '0;
  logic        m_tick  = 1'b0;

  seg_scan_ctrl #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .sel        (sel),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [3:0] h);
    case (h)
      4'h0: enc = 8'hC0; 4'h1: enc = 8'hF9; 4'h2: enc = 8'hA4; 4'h3: enc = 8'hB0;
      4'h4: enc = 8'h99; 4'h5: enc = 8'h92; 4'h6: enc = 8'h82; 4'h7: enc = 8'hF8;
      4'h8: enc = 8'h80; 4'h9: enc = 8'h90; 4'hA: enc = 8'h88; 4'hB: enc = 8'h83;
      4'hC: enc = 8'hC6; 4'hD: enc = 8'hA1; 4'hE: enc = 8'h86; default: enc = 8'h8E;
    endcase
  endfunction

  function automatic logic [11:0] m_expect();
    int         i;
    logic       lz;
    logic [7:0] pat;
    logic [3:0] h;
    if (!m_run) return {3'd0, 8'hFF, 1'b0};
    i = m_cnt / DIV;
    h = 4'((m_data >> (4 * i)) & 32'hF);
`ifdef SEG_LZ_BLANK_EN
    lz = (i > 0) && ((m_data >> (4 * i)) == 32'd0) && !m_dp[i];
`else
    lz = 1'b0;
`endif
    pat = enc(h);
    if (m_blank[i] || lz) pat = 8'hFF;
    else pat[7] = ~m_dp[i];
    return {3'(i), pat, m_tick};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model: advance on each clock edge and push the expected registered outputs.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 1'b0; m_cnt = 0; m_data = '0; m_dp = '0; m_blank = '0; m_tick = 1'b0;
      exp_q.delete();
    end else begin
      m_tick = 1'b0;
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1; m_cnt = 0; m_tick = 1'b1;
          m_data = data; m_dp = dp; m_blank = blank;
        end
      end else if (!en) begin
        m_run = 1'b0;
      end else begin
        m_cnt = (m_cnt + 1) % FRAME;
        if (m_cnt == 0) begin
          m_tick = 1'b1;
          m_data = data; m_dp = dp; m_blank = blank;
        end
      end
      exp_q.push_back(m_expect());
    end
  end

  // Scoreboard: compare DUT outputs on the falling edge.
  initial forever begin
    logic [11:0] e;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_sel", 32'(sel), 32'd0);
      chk("reset_seg", 32'(seg), 32'hFF);
      chk("reset_tick", 32'(frame_tick), 32'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("sb_sel%0d", e[11:9]), 32'({sel, seg, frame_tick}), 32'(e));
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < BOUND);
    if (frame_tick !== 1'b1) chk("wait_tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  task automatic wait_sel(input logic [2:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel !== v && n < BOUND);
    if (sel !== v) chk("wait_sel_timeout", 32'(sel), 32'(v));
  endtask

  // Record one full frame starting at the next frame_tick; optionally change data at sel 3.
  task automatic capture_frame(input bit mid_change);
    int  n;
    bit  done = 1'b0;
    wait_tick(n);
    obs_seg[sel] = seg;
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      obs_seg[sel] = seg;
      if (mid_change && !done && sel == 3'd3) begin
        data = 32'hFFFF_FFFF;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    exp2 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    // Reset with en held high, then release.
    en = 1'b1; data = 32'h7654_3210; dp = '0; blank = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    chk("first_tick_latency", 32'(n), 32'd1);
    chk("first_sel", 32'(sel), 32'd0);
    wait_tick(n);
    chk("frame_period", 32'(n), 32'(FRAME));

    // Digit patterns for 0..7.
    capture_frame(1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_digit%0d", i), 32'(obs_seg[i]), 32'(exp2[i]));

    // Mid-frame data change is deferred to the next frame.
    capture_frame(1'b1);
    for (int i = 3; i < 8; i++) chk($sformatf("t3_old_digit%0d", i), 32'(obs_seg[i]), 32'(exp2[i]));
    capture_frame(1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_new_digit%0d", i), 32'(obs_seg[i]), 32'h8E);

    // Blank mask and decimal point.
    blank = 8'h0F; dp = 8'h10;
    capture_frame(1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_blank_digit%0d", i), 32'(obs_seg[i]), 32'hFF);
    chk("t4_dp_digit4", 32'(obs_seg[4]), 32'h0E);
    chk("t4_plain_digit5", 32'(obs_seg[5]), 32'h8E);

    // Drop en at digit 5, re-raise on the next edge: full restart with a fresh snapshot.
    blank = '0; dp = '0;
    wait_sel(3'd5);
    en = 1'b0;
    @(negedge clk);
    chk("t5_off_sel", 32'(sel), 32'd0);
    chk("t5_off_seg", 32'(seg), 32'hFF);
    data = 32'h1234_5678; en = 1'b1;
    @(negedge clk);
    chk("t5_restart_sel", 32'(sel), 32'd0);
    chk("t5_restart_seg", 32'(seg), 32'h80);
    chk("t5_restart_tick", 32'(frame_tick), 32'd1);

    // Asynchronous reset mid-dwell, then stay idle until en.
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_sel", 32'(sel), 32'd0);
    chk("t5_async_seg", 32'(seg), 32'hFF);
    chk("t5_async_tick", 32'(frame_tick), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_idle_seg", 32'(seg), 32'hFF);

    // Leading zeros.
    data = 32'h0000_0120; dp = '0; blank = '0; en = 1'b1;
    capture_frame(1'b0);
    chk("t6_digit0", 32'(obs_seg[0]), 32'hC0);
    chk("t6_digit1", 32'(obs_seg[1]), 32'hA4);
    chk("t6_digit2", 32'(obs_seg[2]), 32'hF9);
    for (int i = 3; i < 8; i++) begin
`ifdef SEG_LZ_BLANK_EN
      chk($sformatf("t6_lz_digit%0d", i), 32'(obs_seg[i]), 32'hFF);
`else
      chk($sformatf("t6_lz_digit%0d", i), 32'(obs_seg[i]), 32'hC0);
`endif
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
